uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte-stream requesters, legal range 2..8.
REQ-002 Parameter MAX_PKT_LEN, default 64: maximum bytes per grant before a forced release, legal range 2..255.
REQ-003 Localparam IDW = clog2(NUM_REQ): width of the requester ID.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 s_axis_tdata  in  8*NUM_REQ  requester bytes; requester i occupies bits [8i+7:8i].
REQ-007 s_axis_tvalid  in  NUM_REQ  per-requester valid.
REQ-008 s_axis_tlast  in  NUM_REQ  per-requester end-of-packet marker.
REQ-009 s_axis_tready  out  NUM_REQ  per-requester ready; at most one bit high in any cycle.
REQ-010 m_axis_tdata  out  8  merged byte stream toward the UART TX handler.
REQ-011 m_axis_tvalid  out  1  merged valid.
REQ-012 m_axis_tlast  out  1  merged end-of-packet.
REQ-013 m_axis_tready  in  1  downstream ready (UART TX handler s_axis_tready).
REQ-014 grant_id  out  IDW  currently or most recently granted requester.
REQ-015 busy  out  1  high while in any state other than IDLE.
REQ-016 pkt_trunc  out  1  one-cycle pulse when a grant is force-released at MAX_PKT_LEN.

Function
REQ-017 FSM states SHALL be IDLE, (HDR if compiled in), XFER.
REQ-018 In IDLE with any tvalid high, the block SHALL pick a winner by round-robin starting at (last_winner+1) mod NUM_REQ, latch it into grant_id, and move to XFER (or HDR) on the next cycle; no byte is accepted in the arbitration cycle.
REQ-019 In IDLE with no tvalid high, the block SHALL remain in IDLE and grant_id SHALL hold its value.
REQ-020 Output stage SHALL be a single registered slot; m_axis_* are driven only from that slot.
REQ-021 Slot SHALL load when it is empty, or when m_axis_tready is high in the same cycle (back-to-back, full throughput).
REQ-022 In XFER, s_axis_tready[grant_id] SHALL equal the slot load condition; all other tready bits SHALL be 0.
REQ-023 Latency from an accepted input byte to m_axis_tvalid SHALL be exactly 1 cycle.
REQ-024 An 8-bit byte counter SHALL clear on entry to XFER and increment on each accepted byte.
REQ-025 An accepted byte with tlast=1 SHALL be loaded with m_axis_tlast=1, and the FSM SHALL return to IDLE on the next cycle.
REQ-026 If the accepted byte is byte number MAX_PKT_LEN and its tlast=0:
  - it SHALL be loaded with m_axis_tlast=1;
  - pkt_trunc SHALL pulse;
  - the FSM SHALL return to IDLE.
  The requester's remaining bytes then compete as a new packet.
REQ-027 A deasserted granted tvalid mid-packet SHALL stall the block in XFER without a timeout, and the grant SHALL be held.
REQ-028 Re-arbitration SHALL NOT wait for the output slot to drain; the slot's final byte is still presented while IDLE arbitrates.
REQ-029 m_axis_tdata and m_axis_tlast SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.

Reset
REQ-030 On rst_n low, reset SHALL take effect immediately:
  - state=IDLE;
  - slot empty, so m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0;
  - s_axis_tready=0;
  - grant_id=NUM_REQ-1, so requester 0 wins first;
  - counter=0, busy=0, pkt_trunc=0.
REQ-031 Reset asserted mid-packet SHALL discard the slot contents and the partial packet; no tlast is emitted.

Configuration
REQ-032 Macro UART_TX_ARB_HDR_EN SHALL control header insertion.
REQ-033 With UART_TX_ARB_HDR_EN defined:
  - state HDR exists between IDLE and XFER;
  - HDR loads one header byte {4'hA, zero-extended grant_id} into the slot with tlast=0, using the slot rule of REQ-021;
  - all s_axis_tready bits are 0 during HDR;
  - the header does not count toward MAX_PKT_LEN.
REQ-034 Without UART_TX_ARB_HDR_EN, HDR SHALL not exist and IDLE SHALL go directly to XFER.

Structure
REQ-035 Shared package uart_tx_arb_pkg SHALL hold the state enum, the header nibble constant 4'hA, and the IDW helper function.
REQ-036 Round-robin selection SHALL live in sub-module rr_arbiter, with inputs req and last, and outputs onehot grant, encoded index and any.

Verification
REQ-037 Bench SHALL cover these scenarios:
  - Reset, then req1 sends 3 bytes 11,22,33 with tlast on 33, m_axis_tready=1 -> output 11,22,33 with tlast on 33, each 1 cycle after acceptance; grant_id=1.
  - All four requesters hold 2-byte packets -> grant order 0,1,2,3,0; no interleaving within a packet; exactly one tready bit high per cycle.
  - MAX_PKT_LEN=4, req2 sends 6 bytes with no tlast -> tlast on byte 4, pkt_trunc pulses once, bytes 5-6 follow as a new grant.
  - m_axis_tready low for 5 cycles mid-packet -> m_axis_tdata held constant, granted tready low, no byte lost or duplicated.
  - rst_n pulsed low mid-packet -> m_axis_tvalid=0 immediately, grant_id=3, next winner is requester 0.
  - UART_TX_ARB_HDR_EN defined, req3 sends byte 5A -> output A3 then 5A, with tlast only on 5A.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for uart_tx_arbiter.
// The HDR state exists only when UART_TX_ARB_HDR_EN is defined.
package uart_tx_arb_pkg;

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_XFER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd2} state_t;
`endif

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  // Requester ID width; a 2-requester build still needs one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the UART TX handler.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [8*NUM_REQ-1:0] s_axis_tdata;
  logic [NUM_REQ-1:0]   s_axis_tvalid;
  logic [NUM_REQ-1:0]   s_axis_tlast;
  logic [NUM_REQ-1:0]   s_axis_tready;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from (last+1) mod N upward.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IDW'((32'(last) + gi + 1) % N);
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = last;
    any   = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant          = '0;
        grant[cand[k]] = 1'b1;
        idx            = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Merges NUM_REQ byte streams into one registered stream for a UART TX handler.
// Optional per-grant header byte is enabled by defining UART_TX_ARB_HDR_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  MAX_PKT_LEN = 64,
  localparam int IDW         = id_width(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_tx_arbiter_if.master      bus,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   pkt_trunc
);

  localparam logic [NUM_REQ-1:0] OH_RST = {1'b1, {(NUM_REQ-1){1'b0}}};

  state_t               state_reg, state_next;
  logic [IDW-1:0]       grant_reg, grant_next;
  logic [NUM_REQ-1:0]   grant_oh_reg, grant_oh_next;
  logic [7:0]           cnt_reg, cnt_next;
  logic                 slot_valid_reg, slot_valid_next;
  logic                 slot_last_reg, slot_last_next;
  logic [7:0]           slot_data_reg, slot_data_next;
  logic                 trunc_reg, trunc_next;
  logic [NUM_REQ-1:0]   tready_int;

  logic [7:0]           s_byte [NUM_REQ];
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_any;
  logic                 load_ok;
  logic                 g_valid;
  logic                 g_last;
  logic                 at_max;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign s_byte[gi] = bus.s_axis_tdata[8*gi +: 8];
    end
  endgenerate

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr (
    .req   (bus.s_axis_tvalid),
    .last  (grant_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // The slot may refill in the same cycle it is being drained.
  assign load_ok = !slot_valid_reg || bus.m_axis_tready;
  assign g_valid = bus.s_axis_tvalid[grant_reg];
  assign g_last  = bus.s_axis_tlast[grant_reg];
  assign at_max  = (cnt_reg == 8'(MAX_PKT_LEN - 1));

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    grant_oh_next   = grant_oh_reg;
    cnt_next        = cnt_reg;
    slot_valid_next = slot_valid_reg && !bus.m_axis_tready;
    slot_data_next  = slot_data_reg;
    slot_last_next  = slot_last_reg;
    trunc_next      = 1'b0;
    tready_int      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          grant_next    = arb_idx;
          grant_oh_next = arb_grant;
          cnt_next      = '0;
`ifdef UART_TX_ARB_HDR_EN
          state_next    = ST_HDR;
`else
          state_next    = ST_XFER;
`endif
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      ST_HDR: begin
        if (load_ok) begin
          slot_valid_next = 1'b1;
          slot_data_next  = {HDR_NIBBLE, 4'(grant_reg)};
          slot_last_next  = 1'b0;
          state_next      = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        tready_int = load_ok ? grant_oh_reg : '0;
        if (load_ok && g_valid) begin
          slot_valid_next = 1'b1;
          slot_data_next  = s_byte[grant_reg];
          slot_last_next  = g_last || at_max;
          cnt_next        = cnt_reg + 8'd1;
          if (g_last || at_max) begin
            state_next = ST_IDLE;
            trunc_next = at_max && !g_last;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= IDW'(NUM_REQ - 1);
      grant_oh_reg   <= OH_RST;
      cnt_reg        <= '0;
      slot_valid_reg <= 1'b0;
      slot_last_reg  <= 1'b0;
      slot_data_reg  <= '0;
      trunc_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      grant_oh_reg   <= grant_oh_next;
      cnt_reg        <= cnt_next;
      slot_valid_reg <= slot_valid_next;
      slot_last_reg  <= slot_last_next;
      slot_data_reg  <= slot_data_next;
      trunc_reg      <= trunc_next;
    end
  end

  assign bus.s_axis_tready = tready_int;
  assign bus.m_axis_tdata  = slot_data_reg;
  assign bus.m_axis_tvalid = slot_valid_reg;
  assign bus.m_axis_tlast  = slot_last_reg;
  assign grant_id          = grant_reg;
  assign busy              = (state_reg != ST_IDLE);
  assign pkt_trunc         = trunc_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: packet-level round-robin model feeds an
// expected queue, an output monitor pops and compares on each m_axis handshake.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXP = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       seg_start;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           pkt_trunc;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .MAX_PKT_LEN (MAXP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_trunc (pkt_trunc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  beat_t stage [N][$];
  beat_t src_q [N][$];
  int    seg_st [N][$];
  int    seg_ln [N][$];
  exp_t  exp_q [$];
  int    exp_trunc  = 0;
  int    seen_trunc = 0;
  int    model_last = N - 1;

  logic [N-1:0] acc_flags = '0;
  int           gap [N];
  logic         gaps_on    = 1'b0;
  logic         rand_ready = 1'b0;
  logic         hold_low   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic stage_byte(input int r, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l; b.seg_start = 1'b0;
    stage[r].push_back(b);
  endtask

  // Cut each requester's bytes into segments (tlast or MAX bytes), then hand
  // segments out in round-robin order starting after the previous winner.
  task automatic issue();
    int    n, cur, r, st, ln;
    bit    found;
    beat_t b;
    exp_t  e;
    for (int q = 0; q < N; q++) begin
      n = 0;
      for (int i = 0; i < stage[q].size(); i++) begin
        if (n == 0) begin
          b = stage[q][i]; b.seg_start = 1'b1; stage[q][i] = b;
          seg_st[q].push_back(i);
        end
        n++;
        if (stage[q][i].last || n == MAXP) begin
          seg_ln[q].push_back(n);
          n = 0;
        end
      end
    end
    cur = model_last;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        r = (cur + k) % N;
        if (!found && seg_ln[r].size() > 0) begin
          found = 1'b1;
`ifdef UART_TX_ARB_HDR_EN
          e.data = {HDR_NIBBLE, 4'(r)}; e.last = 1'b0;
          exp_q.push_back(e);
`endif
          st = seg_st[r].pop_front();
          ln = seg_ln[r].pop_front();
          for (int j = 0; j < ln; j++) begin
            e.data = stage[r][st+j].data;
            e.last = (j == ln - 1);
            exp_q.push_back(e);
          end
          if (!stage[r][st+ln-1].last) exp_trunc++;
          cur = r;
        end
      end
    end
    model_last = cur;
    for (int q = 0; q < N; q++) begin
      for (int i = 0; i < stage[q].size(); i++) src_q[q].push_back(stage[q][i]);
      stage[q].delete();
    end
  endtask

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int q = 0; q < N; q++) if (src_q[q].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || src_pending() || busy || bus.m_axis_tvalid) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc >= 2000) begin
      bad++;
      $display("FAIL %s_drain expected_left=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    chk({name, "_grant_id"}, 32'(grant_id), 32'(model_last));
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_out_valid(input string name);
    int cyc = 0;
    while (!bus.m_axis_tvalid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_first_out"}, 32'(bus.m_axis_tvalid), 32'd1);
  endtask

  // Source drivers: advance on acceptance, optional mid-segment valid gaps.
  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b0;
    for (int q = 0; q < N; q++) gap[q] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.s_axis_tvalid = '0;
        for (int q = 0; q < N; q++) gap[q] = 0;
      end else begin
        for (int q = 0; q < N; q++) begin
          if (acc_flags[q] && src_q[q].size() > 0) begin
            void'(src_q[q].pop_front());
            if (gaps_on && src_q[q].size() > 0 && !src_q[q][0].seg_start
                && $urandom_range(0, 3) == 0)
              gap[q] = $urandom_range(1, 3);
          end
          if (gap[q] > 0) begin
            gap[q]--;
            bus.s_axis_tvalid[q] = 1'b0;
          end else if (src_q[q].size() > 0) begin
            bus.s_axis_tvalid[q]        = 1'b1;
            bus.s_axis_tdata[8*q +: 8]  = src_q[q][0].data;
            bus.s_axis_tlast[q]         = src_q[q][0].last;
          end else begin
            bus.s_axis_tvalid[q] = 1'b0;
            bus.s_axis_tlast[q]  = 1'b0;
          end
        end
      end
      bus.m_axis_tready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Output monitor: scoreboard pop, latency, hold-while-stalled, tready rules.
  initial begin
    logic       lat_pend   = 1'b0;
    logic [7:0] lat_data   = '0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    logic [N-1:0] acc;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_flags  = '0;
        lat_pend   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        total++;
        if ($countones(bus.s_axis_tready) > 1) begin
          bad++;
          $display("FAIL tready_onehot actual=%b required=at most one bit", bus.s_axis_tready);
        end
        if (lat_pend) begin
          total++;
          if (!(bus.m_axis_tvalid && bus.m_axis_tdata == lat_data)) begin
            bad++;
            $display("FAIL latency actual=valid %b data %h required=valid 1 data %h",
                     bus.m_axis_tvalid, bus.m_axis_tdata, lat_data);
          end
        end
        if (prev_stall) begin
          total++;
          if (!bus.m_axis_tvalid || bus.m_axis_tdata != prev_data || bus.m_axis_tlast != prev_last) begin
            bad++;
            $display("FAIL hold actual=%b/%h/%b required=1/%h/%b", bus.m_axis_tvalid,
                     bus.m_axis_tdata, bus.m_axis_tlast, prev_data, prev_last);
          end
        end
        if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
          total++;
          if (bus.s_axis_tready != '0) begin
            bad++;
            $display("FAIL stall_tready actual=%b required=0", bus.s_axis_tready);
          end
        end
        if (pkt_trunc) begin
          seen_trunc++;
          total++;
          if (!(bus.m_axis_tvalid && bus.m_axis_tlast)) begin
            bad++;
            $display("FAIL trunc_align actual=valid %b last %b required=1 1",
                     bus.m_axis_tvalid, bus.m_axis_tlast);
          end
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL out_extra actual=%h/%b required=no output", bus.m_axis_tdata, bus.m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            if (e.data != bus.m_axis_tdata || e.last != bus.m_axis_tlast) begin
              bad++;
              $display("FAIL out_byte actual=%h/%b required=%h/%b",
                       bus.m_axis_tdata, bus.m_axis_tlast, e.data, e.last);
            end else begin
              $display("out byte=%h last=%b grant_id=%0d", bus.m_axis_tdata, bus.m_axis_tlast, grant_id);
            end
          end
        end
        acc      = bus.s_axis_tvalid & bus.s_axis_tready;
        acc_flags = acc;
        lat_pend = |acc;
        for (int q = 0; q < N; q++) if (acc[q]) lat_data = bus.s_axis_tdata[8*q +: 8];
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_data  = bus.m_axis_tdata;
        prev_last  = bus.m_axis_tlast;
      end
    end
  end

  task automatic reset_checks(input string name);
    chk({name, "_m_valid"}, 32'(bus.m_axis_tvalid), 32'd0);
    chk({name, "_m_last"}, 32'(bus.m_axis_tlast), 32'd0);
    chk({name, "_m_data"}, 32'(bus.m_axis_tdata), 32'd0);
    chk({name, "_s_ready"}, 32'(bus.s_axis_tready), 32'd0);
    chk({name, "_grant_id"}, 32'(grant_id), 32'(N - 1));
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_pkt_trunc"}, 32'(pkt_trunc), 32'd0);
  endtask

  initial begin
    int npk;
    int len;
    #1 rst_n = 1'b0;
    #2 reset_checks("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single packet from requester 1.
    stage_byte(1, 8'h11, 1'b0);
    stage_byte(1, 8'h22, 1'b0);
    stage_byte(1, 8'h33, 1'b1);
    issue();
    wait_drain("single");

    // Every requester holds two 2-byte packets.
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < N; q++) begin
        stage_byte(q, 8'($urandom_range(0, 255)), 1'b0);
        stage_byte(q, 8'($urandom_range(0, 255)), 1'b1);
      end
    issue();
    wait_drain("all_rr");

    // Requester 2 overruns MAX_PKT_LEN while requester 3 waits.
    for (int i = 0; i < 7; i++) stage_byte(2, 8'(8'h21 + i), i == 6);
    stage_byte(3, 8'h31, 1'b0);
    stage_byte(3, 8'h32, 1'b1);
    issue();
    wait_drain("trunc");
    chk("trunc_count", 32'(seen_trunc), 32'(exp_trunc));

    // Downstream stall for 5 cycles mid-packet.
    stage_byte(0, 8'hC1, 1'b0);
    stage_byte(0, 8'hC2, 1'b0);
    stage_byte(0, 8'hC3, 1'b1);
    issue();
    wait_out_valid("stall");
    hold_low = 1'b1;
    repeat (5) @(negedge clk);
    hold_low = 1'b0;
    wait_drain("stall");

    // Reset mid-packet, then requester 0 must win first.
    stage_byte(1, 8'hD1, 1'b0);
    stage_byte(1, 8'hD2, 1'b0);
    stage_byte(1, 8'hD3, 1'b1);
    issue();
    wait_out_valid("midrst");
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    exp_q.delete();
    for (int q = 0; q < N; q++) src_q[q].delete();
    model_last = N - 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    stage_byte(2, 8'hE1, 1'b0);
    stage_byte(2, 8'hE2, 1'b1);
    stage_byte(0, 8'hF1, 1'b0);
    stage_byte(0, 8'hF2, 1'b1);
    issue();
    wait_drain("after_rst");

    // Randomised traffic with valid gaps and random downstream ready.
    gaps_on    = 1'b1;
    rand_ready = 1'b1;
    for (int round = 0; round < 6; round++) begin
      for (int q = 0; q < N; q++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 7);
          for (int i = 0; i < len; i++) stage_byte(q, 8'($urandom_range(0, 255)), i == len - 1);
        end
      end
      issue();
      wait_drain("random");
    end
    gaps_on    = 1'b0;
    rand_ready = 1'b0;

    // Single byte from requester 3 (header-framed when compiled in).
    stage_byte(3, 8'h5A, 1'b1);
    issue();
    wait_drain("hdr");

    chk("trunc_total", 32'(seen_trunc), 32'(exp_trunc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
